regfile_sb: RTL and testbench

//  Parametrised multi-port integer register file with a per-register busy scoreboard, for the in-order superscalar core.

---
 rtl/regfile_sb_pkg.sv | 23 ++
 rtl/regfile_sb_scoreboard.sv | 73 +++++++
 rtl/regfile_sb.sv | 95 +++++++++
 tb/tb_regfile_sb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared types and constants for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int unsigned NREG_DEFAULT = 32;
  localparam int unsigned RF_DATA_W    = 32;
  localparam int unsigned RF_ADDR_W    = $clog2(NREG_DEFAULT);

  localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

  // Writeback port payload
  typedef struct packed {
    logic                 wen;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] wd;
  } rf_w_t;

  // Issue (destination reservation) payload
  typedef struct packed {
    logic                 en;
    logic [RF_ADDR_W-1:0] addr;
  } rf_isu_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy vector: issue sets, writeback clears, flush clears all.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int unsigned NREG    = NREG_DEFAULT,
  parameter int unsigned NUM_WR  = 2,
  parameter int unsigned NUM_ISU = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  rf_isu_t         clr   [NUM_WR],
  input  rf_isu_t         isu   [NUM_ISU],
  input  logic            flush,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] wb_clr;
  logic            waw_viol;
  logic            dup_isu;

  // Registers cleared by a writeback this cycle
  always_comb begin
    wb_clr = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (clr[j].en && clr[j].addr != REG_ZERO) wb_clr[clr[j].addr] = 1'b1;
    end
  end

  // Next busy state: flush dominates, then set beats clear (issuer is younger)
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d = busy_q & ~wb_clr;
      for (int unsigned i = 0; i < NUM_ISU; i++) begin
        if (isu[i].en && isu[i].addr != REG_ZERO) busy_d[isu[i].addr] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

  // Protocol checks: WAW issue to a still-busy register, duplicate issue targets
  always_comb begin
    waw_viol = 1'b0;
    dup_isu  = 1'b0;
    for (int unsigned i = 0; i < NUM_ISU; i++) begin
      if (isu[i].en && isu[i].addr != REG_ZERO && !flush) begin
        if (busy_q[isu[i].addr] && !wb_clr[isu[i].addr]) waw_viol = 1'b1;
        for (int unsigned k = i + 1; k < NUM_ISU; k++) begin
          if (isu[k].en && isu[k].addr == isu[i].addr) dup_isu = 1'b1;
        end
      end
    end
  end

  a_no_waw_issue : assert property (@(posedge clk) disable iff (!reset) !waw_viol)
    else $error("regfile_scoreboard: issue to a register that is still busy");

  a_no_dup_issue : assert property (@(posedge clk) disable iff (!reset) !dup_isu)
    else $error("regfile_scoreboard: two issue ports name the same register");

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with busy scoreboard and R0 hardwired to zero.
// Optional macro RF_BYPASS_EN forwards same-cycle writeback data to reads.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned NREG    = NREG_DEFAULT,
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned NUM_WR  = 2,
  parameter int unsigned NUM_RD  = 4,
  parameter int unsigned NUM_ISU = 2,
  parameter int unsigned ADDR_W  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  rf_w_t               rfw      [NUM_WR],
  input  logic [NUM_ISU-1:0]  isu_en,
  input  logic [ADDR_W-1:0]   isu_addr [NUM_ISU],
  input  logic                flush,
  input  logic [ADDR_W-1:0]   rd_addr  [NUM_RD],
  output logic [DATA_W-1:0]   rd_data  [NUM_RD],
  output logic [NUM_RD-1:0]   rd_rdy
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy;
  rf_isu_t           sb_clr [NUM_WR];
  rf_isu_t           sb_isu [NUM_ISU];

  // Repack writeback and issue ports for the scoreboard
  always_comb begin
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      sb_clr[j]      = '0;
      sb_clr[j].en   = rfw[j].wen;
      sb_clr[j].addr = rfw[j].addr;
    end
    for (int unsigned i = 0; i < NUM_ISU; i++) begin
      sb_isu[i]      = '0;
      sb_isu[i].en   = isu_en[i];
      sb_isu[i].addr = RF_ADDR_W'(isu_addr[i]);
    end
  end

  regfile_scoreboard #(
    .NREG    (NREG),
    .NUM_WR  (NUM_WR),
    .NUM_ISU (NUM_ISU)
  ) u_scoreboard (
    .clk   (clk),
    .reset (reset),
    .clr   (sb_clr),
    .isu   (sb_isu),
    .flush (flush),
    .busy  (busy)
  );

  // Write-priority mux: iterate oldest to youngest so port 0 lands last
  always_comb begin
    regs_d = regs_q;
    for (int j = int'(NUM_WR) - 1; j >= 0; j--) begin
      if (rfw[j].wen && rfw[j].addr != REG_ZERO) regs_d[rfw[j].addr] = DATA_W'(rfw[j].wd);
    end
    regs_d[0] = '0;
  end

  // Data array register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NREG; k++) regs_q[k] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes with ready flag and optional same-cycle forwarding
  always_comb begin
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_data[p] = '0;
      rd_rdy[p]  = 1'b1;
      if (rd_addr[p] != '0) begin
        rd_data[p] = regs_q[rd_addr[p]];
        rd_rdy[p]  = ~busy[rd_addr[p]];
`ifdef RF_BYPASS_EN
        for (int j = int'(NUM_WR) - 1; j >= 0; j--) begin
          if (rfw[j].wen && ADDR_W'(rfw[j].addr) == rd_addr[p]) begin
            rd_data[p] = DATA_W'(rfw[j].wd);
            rd_rdy[p]  = 1'b1;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; expectations queued then checked against reads.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int unsigned NUM_WR  = 2;
  localparam int unsigned NUM_RD  = 4;
  localparam int unsigned NUM_ISU = 2;
  localparam int unsigned AW      = RF_ADDR_W;
  localparam int unsigned DW      = RF_DATA_W;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk;
  logic               reset;
  rf_w_t              rfw      [NUM_WR];
  logic [NUM_ISU-1:0] isu_en;
  logic [AW-1:0]      isu_addr [NUM_ISU];
  logic               flush;
  logic [AW-1:0]      rd_addr  [NUM_RD];
  logic [DW-1:0]      rd_data  [NUM_RD];
  logic [NUM_RD-1:0]  rd_rdy;

  regfile_sb #(
    .NREG    (NREG_DEFAULT),
    .DATA_W  (DW),
    .NUM_WR  (NUM_WR),
    .NUM_RD  (NUM_RD),
    .NUM_ISU (NUM_ISU)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rfw      (rfw),
    .isu_en   (isu_en),
    .isu_addr (isu_addr),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_rdy   (rd_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    int            port;
    logic [DW-1:0] data;
    logic          rdy;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic clr_inputs();
    for (int j = 0; j < int'(NUM_WR); j++) rfw[j] = '0;
    for (int i = 0; i < int'(NUM_ISU); i++) isu_addr[i] = '0;
    isu_en = '0;
    flush  = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rfw[p].wen  = 1'b1;
    rfw[p].addr = a;
    rfw[p].wd   = d;
  endtask

  task automatic issue(input int p, input logic [AW-1:0] a);
    isu_en[p]   = 1'b1;
    isu_addr[p] = a;
  endtask

  task automatic expect_rd(input string tag, input int port, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic r);
    exp_t e;
    rd_addr[port] = a;
    e.tag  = tag;
    e.port = port;
    e.data = d;
    e.rdy  = r;
    sb_q.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_cmp++;
      assert (rd_data[e.port] === e.data) else begin
        n_mis++;
        $error("FAIL %s data port%0d: got %h want %h", e.tag, e.port, rd_data[e.port], e.data);
      end
      n_cmp++;
      assert (rd_rdy[e.port] === e.rdy) else begin
        n_mis++;
        $error("FAIL %s rdy port%0d: got %b want %b", e.tag, e.port, rd_rdy[e.port], e.rdy);
      end
    end
  endtask

  // Advance one edge, then return inputs to idle
  task automatic tick();
    @(posedge clk);
    #1;
    clr_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clr_inputs();
    for (int p = 0; p < int'(NUM_RD); p++) rd_addr[p] = '0;
    #1;
    // Reset state
    expect_rd("rst_p0", 0, 5'd0,  '0, 1'b1);
    expect_rd("rst_p1", 1, 5'd5,  '0, 1'b1);
    expect_rd("rst_p2", 2, 5'd7,  '0, 1'b1);
    expect_rd("rst_p3", 3, 5'd31, '0, 1'b1);
    check_all();
    reset = 1'b1;
    tick();

    // T2: write priority, port 0 wins
    wr(0, 5'd7, 32'hAAAA);
    wr(1, 5'd7, 32'hBBBB);
    expect_rd("t2_same", 0, 5'd7, BYP ? 32'hAAAA : 32'h0, 1'b1);
    check_all();
    tick();
    expect_rd("t2_next", 0, 5'd7, 32'hAAAA, 1'b1);
    check_all();

    // T3: zero register ignores write and issue
    wr(1, 5'd0, 32'hFFFF);
    issue(0, 5'd0);
    expect_rd("t3_c0", 1, 5'd0, '0, 1'b1);
    check_all();
    tick();
    expect_rd("t3_c1", 1, 5'd0, '0, 1'b1);
    check_all();

    // T4: scoreboard set, then writeback + re-issue in same cycle
    issue(0, 5'd3);
    expect_rd("t4_c0", 0, 5'd3, '0, 1'b1);
    check_all();
    tick();
    expect_rd("t4_c1", 0, 5'd3, '0, 1'b0);
    check_all();
    tick();
    expect_rd("t4_c2", 0, 5'd3, '0, 1'b0);
    check_all();
    tick();
    expect_rd("t4_c3", 0, 5'd3, '0, 1'b0);
    check_all();
    tick();
    wr(0, 5'd3, 32'h55);
    issue(0, 5'd3);
    expect_rd("t4_c4", 0, 5'd3, BYP ? 32'h55 : 32'h0, BYP);
    check_all();
    tick();
    expect_rd("t4_c5", 0, 5'd3, 32'h55, 1'b0);
    check_all();
    wr(0, 5'd3, 32'h66);
    tick();
    expect_rd("t4_done", 0, 5'd3, 32'h66, 1'b1);
    check_all();

    // T5: flush clears busy, squashes issue, keeps writeback data
    issue(0, 5'd8);
    issue(1, 5'd9);
    tick();
    expect_rd("t5_b8", 0, 5'd8, '0, 1'b0);
    expect_rd("t5_b9", 1, 5'd9, '0, 1'b0);
    check_all();
    flush = 1'b1;
    issue(0, 5'd10);
    wr(0, 5'd8, 32'h9);
    expect_rd("t5_fl", 2, 5'd8, BYP ? 32'h9 : 32'h0, BYP);
    check_all();
    tick();
    expect_rd("t5_r8",  0, 5'd8,  32'h9, 1'b1);
    expect_rd("t5_r9",  1, 5'd9,  '0,    1'b1);
    expect_rd("t5_r10", 2, 5'd10, '0,    1'b1);
    check_all();

    // T6: same-cycle read of a write in flight
    wr(0, 5'd4, 32'h1111);
    tick();
    wr(0, 5'd4, 32'hC0DE);
    expect_rd("t6_same", 2, 5'd4, BYP ? 32'hC0DE : 32'h1111, 1'b1);
    check_all();
    tick();
    expect_rd("t6_next", 2, 5'd4, 32'hC0DE, 1'b1);
    check_all();

    // Forwarding on port 1 while the target is busy
    issue(0, 5'd12);
    tick();
    wr(1, 5'd12, 32'hBEEF);
    expect_rd("byb_same", 3, 5'd12, BYP ? 32'hBEEF : 32'h0, BYP);
    check_all();
    tick();
    expect_rd("byb_next", 3, 5'd12, 32'hBEEF, 1'b1);
    check_all();

    // T1: async reset mid-run, visible before any clock edge
    wr(0, 5'd5, 32'h1234);
    issue(0, 5'd13);
    tick();
    expect_rd("t1_pre5",  0, 5'd5,  32'h1234, 1'b1);
    expect_rd("t1_pre13", 1, 5'd13, '0,       1'b0);
    check_all();
    reset = 1'b0;
    expect_rd("t1_r5",  0, 5'd5,  '0, 1'b1);
    expect_rd("t1_r13", 1, 5'd13, '0, 1'b1);
    expect_rd("t1_r7",  2, 5'd7,  '0, 1'b1);
    expect_rd("t1_r4",  3, 5'd4,  '0, 1'b1);
    check_all();
    #1;
    reset = 1'b1;
    tick();
    wr(0, 5'd5, 32'h77);
    tick();
    expect_rd("t1_post5", 0, 5'd5, 32'h77, 1'b1);
    expect_rd("t1_post7", 1, 5'd7, '0,     1'b1);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
